// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data cache.
//   state_t        : controller states
//   W_*            : RISC-V funct3 load/store width encodings
//   DC_*           : default geometry and the derived address field widths
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REFILL   = 2'd1,
    WRITE    = 2'd2,
    UNCACHED = 2'd3
  } state_t;

  localparam logic [2:0] W_B  = 3'b000;
  localparam logic [2:0] W_H  = 3'b001;
  localparam logic [2:0] W_W  = 3'b010;
  localparam logic [2:0] W_BU = 3'b100;
  localparam logic [2:0] W_HU = 3'b101;

  localparam int unsigned DC_LINES          = 16;
  localparam int unsigned DC_WORDS_PER_LINE = 4;
  localparam logic [31:0] DC_UNCACHED_BASE  = 32'h0001_0000;

  localparam int unsigned OFFSET_BITS = 2;
  localparam int unsigned LINE_BITS   = $clog2(DC_LINES);
  localparam int unsigned WORD_BITS   = $clog2(DC_WORDS_PER_LINE);
  localparam int unsigned TAG_BITS    = 32 - LINE_BITS - WORD_BITS - OFFSET_BITS;

endpackage

// File: rtl/dcache_align.sv
// dcache_align: combinational load extraction and store byte merging.
//   word_i   : 32-bit word read from the array or from backing memory
//   offset_i : byte offset addr[1:0]
//   width_i  : funct3 width code
//   wdata_i  : unshifted store data
//   load_o   : selected byte/half/word, sign- or zero-extended
//   merge_o  : word_i with the store bytes replaced
module dcache_align
  import dcache_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  width_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? word_i[31:16] : word_i[15:0];
    case (width_i)
      W_B:     load_o = {{24{byte_v[7]}}, byte_v};
      W_BU:    load_o = {24'h0, byte_v};
      W_H:     load_o = {{16{half_v[15]}}, half_v};
      W_HU:    load_o = {16'h0, half_v};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (width_i)
      W_B: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      W_H: begin
        if (offset_i[1]) merge_o[31:16] = wdata_i[15:0];
        else             merge_o[15:0]  = wdata_i[15:0];
      end
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst              : clock, asynchronous active-high reset
//   req_i/we_i/addr_i/wdata_i/width_i : memory-stage access (held while stall_o)
//   rdata_o, stall_o      : load result and pipeline freeze
//   mem_*                 : backing-memory request channel
// Backing-memory handshake: mem_req_o is raised with stable mem_we_o,
// mem_addr_o, mem_width_o and mem_wdata_o and held until a cycle in which
// mem_ready_i is also high; that cycle completes the beat. mem_ready_i with
// mem_req_o low is ignored.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned LINES          = DC_LINES,
  parameter int unsigned WORDS_PER_LINE = DC_WORDS_PER_LINE,
  parameter logic [31:0] UNCACHED_BASE  = DC_UNCACHED_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  width_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [2:0]  mem_width_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned LB = $clog2(LINES);
  localparam int unsigned WB = $clog2(WORDS_PER_LINE);
  localparam int unsigned TB = 32 - LB - WB - 2;

  logic [TB-1:0] addr_tag;
  logic [LB-1:0] addr_line;
  logic [WB-1:0] addr_word;

  assign addr_word = addr_i[WB+1:2];
  assign addr_line = addr_i[LB+WB+1:WB+2];
  assign addr_tag  = addr_i[31:LB+WB+2];

  state_t        state_q, state_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0] tag_q [LINES];
  logic [TB-1:0] tag_d [LINES];
  logic [31:0]   data_q [LINES*WORDS_PER_LINE];

  logic          data_we;
  logic [LB+WB-1:0] data_idx;
  logic [31:0]   data_wval;

  logic          hit, cached, is_last;
  logic [31:0]   array_word, align_word, align_load, align_merge;

  assign cached     = (addr_i < UNCACHED_BASE);
  assign hit        = valid_q[addr_line] && (tag_q[addr_line] == addr_tag);
  assign is_last    = (cnt_q == WB'(WORDS_PER_LINE - 1));
  assign array_word = data_q[{addr_line, addr_word}];
  // One aligner serves both the hit path and uncached load returns.
  assign align_word = (state_q == UNCACHED) ? mem_rdata_i : array_word;

  dcache_align u_align (
    .word_i   (align_word),
    .offset_i (addr_i[1:0]),
    .width_i  (width_i),
    .wdata_i  (wdata_i),
    .load_o   (align_load),
    .merge_o  (align_merge)
  );

  // State register and cache metadata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  // Data array: no reset, contents are qualified by valid_q.
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_idx] <= data_wval;
  end

  // Next-state and array update logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    data_we   = 1'b0;
    data_idx  = {addr_line, addr_word};
    data_wval = align_merge;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (we_i) begin
            state_d = WRITE;
          end else if (!cached) begin
            state_d = UNCACHED;
          end else if (!hit) begin
            state_d = REFILL;
            cnt_d   = '0;
            // Drop the old line now so a partial refill is never seen as valid.
            valid_d[addr_line] = 1'b0;
          end
        end
      end
      REFILL: begin
        if (mem_ready_i) begin
          data_we   = 1'b1;
          data_idx  = {addr_line, cnt_q};
          data_wval = mem_rdata_i;
          cnt_d     = cnt_q + WB'(1);
          if (is_last) begin
            valid_d[addr_line] = 1'b1;
            tag_d[addr_line]   = addr_tag;
            state_d            = IDLE;
          end
        end
      end
      WRITE: begin
        if (mem_ready_i) begin
          // No allocate: only an already-present line is updated.
          data_we = cached && hit;
          state_d = IDLE;
        end
      end
      UNCACHED: begin
        if (mem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    stall_o     = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = wdata_i;
    mem_width_o = width_i;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (we_i || !cached) stall_o = 1'b1;
          else if (hit)        rdata_o = align_load;
          else                 stall_o = 1'b1;
        end
      end
      REFILL: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_width_o = W_W;
        mem_addr_o  = {addr_tag, addr_line, cnt_q, 2'b00};
      end
      WRITE: begin
        stall_o    = !mem_ready_i;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = addr_i;
      end
      UNCACHED: begin
        stall_o    = !mem_ready_i;
        mem_req_o  = 1'b1;
        mem_addr_o = addr_i;
        if (mem_ready_i) rdata_o = align_load;
      end
      default: ;
    endcase
  end

endmodule
